// File: rtl/ble_ram_arbiter_if.sv
// Signal bundle around ble_ram_arbiter: CPU Wishbone side, RAM Wishbone side, rx byte strobe
// and ring status. Names carry the arbiter's point of view (i_ = into the arbiter).
interface ble_ram_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                        i_rx_valid;
    logic [7:0]                  i_rx_data;
    logic [31:0]                 i_cpu_adr;
    logic [31:0]                 i_cpu_dat;
    logic [3:0]                  i_cpu_sel;
    logic                        i_cpu_we;
    logic                        i_cpu_cyc;
    logic [31:0]                 o_cpu_rdt;
    logic                        o_cpu_ack;
    logic [31:0]                 o_ram_adr;
    logic [31:0]                 o_ram_dat;
    logic [3:0]                  o_ram_sel;
    logic                        o_ram_we;
    logic                        o_ram_cyc;
    logic [31:0]                 i_ram_rdt;
    logic                        i_ram_ack;
    logic [31:0]                 o_wr_ptr;
    logic [$clog2(FIFO_DEPTH):0] o_fifo_count;
    logic                        o_overflow;

    modport slave (
        input  i_rx_valid, i_rx_data,
        input  i_cpu_adr, i_cpu_dat, i_cpu_sel, i_cpu_we, i_cpu_cyc,
        output o_cpu_rdt, o_cpu_ack,
        output o_ram_adr, o_ram_dat, o_ram_sel, o_ram_we, o_ram_cyc,
        input  i_ram_rdt, i_ram_ack,
        output o_wr_ptr, o_fifo_count, o_overflow
    );

    modport master (
        output i_rx_valid, i_rx_data,
        output i_cpu_adr, i_cpu_dat, i_cpu_sel, i_cpu_we, i_cpu_cyc,
        input  o_cpu_rdt, o_cpu_ack,
        input  o_ram_adr, o_ram_dat, o_ram_sel, o_ram_we, o_ram_cyc,
        output i_ram_rdt, i_ram_ack,
        input  o_wr_ptr, o_fifo_count, o_overflow
    );
endinterface

// File: rtl/ble_ram_arbiter.sv
// Shares the single-port servant_ram between the SERV data bus and a FIFO-buffered uart_rx byte
// ring. Define BLE_ARB_STATUS_EN to add the memory-mapped status/overflow-clear register.
module ble_ram_arbiter #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] ADR_LL     = 32'h0000_0800,
    parameter logic [31:0] ADR_UL     = 32'h0000_1FFC
`ifdef BLE_ARB_STATUS_EN
    ,
    parameter logic [31:0] STATUS_ADR = 32'h00B0_0000
`endif
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst_n,
    ble_ram_arbiter_if.slave io_bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(FIFO_DEPTH);

`ifdef BLE_ARB_STATUS_EN
    typedef enum logic [2:0] {ST_IDLE, ST_GNT_CPU, ST_GNT_RX, ST_GAP, ST_STAT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_GNT_CPU, ST_GNT_RX, ST_GAP} state_t;
`endif

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_idx;
    logic [AW-1:0] r_wr_idx;
    logic [CW-1:0] r_count;
    logic [31:0]   r_wr_ptr;
    logic          r_overflow;
    logic          r_last_grant_cpu;

    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_cpu_done;
    logic          w_ovf_clear;
    logic          w_rx_req;
    logic [31:0]   w_cpu_rdt;
    logic          w_cpu_ack;
    logic [31:0]   w_ram_adr;
    logic [31:0]   w_ram_dat;
    logic [3:0]    w_ram_sel;
    logic          w_ram_we;
    logic          w_ram_cyc;

    assign w_rx_req = (r_count != '0);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push   = io_bus.i_rx_valid && ((r_count != LP_DEPTH) || w_pop);
    assign w_drop   = io_bus.i_rx_valid && !w_push;

`ifdef BLE_ARB_STATUS_EN
    logic        w_stat_req;
    logic [31:0] w_status;

    assign w_stat_req  = io_bus.i_cpu_cyc && (io_bus.i_cpu_adr == STATUS_ADR);
    assign w_status    = {r_overflow, 7'b0, 8'(r_count), r_wr_ptr[15:0]};
    assign w_ovf_clear = (r_state == ST_STAT) && io_bus.i_cpu_cyc && io_bus.i_cpu_we &&
                         io_bus.i_cpu_dat[31] && io_bus.i_cpu_sel[3];
`else
    assign w_ovf_clear = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_ram_adr    = '0;
        w_ram_dat    = '0;
        w_ram_sel    = '0;
        w_ram_we     = 1'b0;
        w_ram_cyc    = 1'b0;
        w_cpu_ack    = 1'b0;
        w_cpu_rdt    = '0;
        w_pop        = 1'b0;
        w_cpu_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef BLE_ARB_STATUS_EN
                if (w_stat_req) begin
                    w_next_state = ST_STAT;
                end else
`endif
                // Contention goes to whichever side was not served last.
                if (io_bus.i_cpu_cyc && w_rx_req) begin
                    w_next_state = r_last_grant_cpu ? ST_GNT_RX : ST_GNT_CPU;
                end else if (io_bus.i_cpu_cyc) begin
                    w_next_state = ST_GNT_CPU;
                end else if (w_rx_req) begin
                    w_next_state = ST_GNT_RX;
                end
            end
            ST_GNT_CPU: begin
                w_ram_adr = io_bus.i_cpu_adr;
                w_ram_dat = io_bus.i_cpu_dat;
                w_ram_sel = io_bus.i_cpu_sel;
                w_ram_we  = io_bus.i_cpu_we;
                w_ram_cyc = io_bus.i_cpu_cyc;
                w_cpu_ack = io_bus.i_ram_ack;
                w_cpu_rdt = io_bus.i_ram_rdt;
                if (io_bus.i_ram_ack) begin
                    w_cpu_done   = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
            ST_GNT_RX: begin
                w_ram_adr = r_wr_ptr;
                w_ram_dat = {24'b0, r_fifo_mem[r_rd_idx]};
                w_ram_sel = 4'b1111;
                w_ram_we  = 1'b1;
                w_ram_cyc = 1'b1;
                if (io_bus.i_ram_ack) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_GAP;
                end
            end
`ifdef BLE_ARB_STATUS_EN
            ST_STAT: begin
                w_cpu_ack    = 1'b1;
                w_cpu_rdt    = w_status;
                w_next_state = ST_GAP;
            end
`endif
            ST_GAP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign io_bus.o_ram_adr    = w_ram_adr;
    assign io_bus.o_ram_dat    = w_ram_dat;
    assign io_bus.o_ram_sel    = w_ram_sel;
    assign io_bus.o_ram_we     = w_ram_we;
    assign io_bus.o_ram_cyc    = w_ram_cyc;
    assign io_bus.o_cpu_ack    = w_cpu_ack;
    assign io_bus.o_cpu_rdt    = w_cpu_rdt;
    assign io_bus.o_wr_ptr     = r_wr_ptr;
    assign io_bus.o_fifo_count = r_count;
    assign io_bus.o_overflow   = r_overflow;

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state          <= ST_IDLE;
            r_wr_ptr         <= ADR_LL;
            r_last_grant_cpu <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_wr_ptr         <= (r_wr_ptr == ADR_UL) ? ADR_LL : r_wr_ptr + 32'd4;
                r_last_grant_cpu <= 1'b0;
            end
            if (w_cpu_done) begin
                r_last_grant_cpu <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_idx] <= io_bus.i_rx_data;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_rd_idx   <= '0;
            r_wr_idx   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear request keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ble_ram_arbiter.sv
// Self-checking bench for ble_ram_arbiter: RAM responder, rx ring scoreboard, CPU vector table,
// directed arbitration/overflow/reset sequences and a randomized mixed-traffic run.
module tb_ble_ram_arbiter;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] LL         = 32'h0000_0800;
    localparam logic [31:0] UL         = 32'h0000_1FFC;
    localparam logic [31:0] STATUS     = 32'h00B0_0000;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] expRdt;
    } vecT;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   vecCount = 0;
    int   missCount = 0;
    int   ackDelay = 0;
    int   waitCnt = 0;
    bit [31:0]   ramMem [2048];
    byte unsigned expRx [$];
    logic [31:0] expPtr = LL;

    always #5 clk = ~clk;

    ble_ram_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    ble_ram_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADR_LL     (LL),
        .ADR_UL     (UL)
    ) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rstN),
        .io_bus     (bus)
    );

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] dat,
                                              input logic [3:0] sel);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = dat[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] nextPtr(input logic [31:0] p);
        return (p == UL) ? LL : p + 32'd4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // RAM responder: acks after ackDelay extra cycles, one-cycle ack pulse.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bus.i_ram_ack <= 1'b0;
            waitCnt       <= 0;
        end else begin
            bus.i_ram_ack <= 1'b0;
            if (bus.o_ram_cyc && !bus.i_ram_ack) begin
                if (waitCnt >= ackDelay) begin
                    bus.i_ram_ack <= 1'b1;
                    waitCnt       <= 0;
                    if (bus.o_ram_we)
                        ramMem[bus.o_ram_adr[12:2]] <= mergeWord(ramMem[bus.o_ram_adr[12:2]],
                                                                 bus.o_ram_dat, bus.o_ram_sel);
                    else
                        bus.i_ram_rdt <= ramMem[bus.o_ram_adr[12:2]];
                end else begin
                    waitCnt <= waitCnt + 1;
                end
            end else begin
                waitCnt <= 0;
            end
        end
    end

    // Ring scoreboard: every acked write inside the ring must be the next accepted byte.
    always @(negedge clk) begin
        if (rstN && bus.i_ram_ack && bus.o_ram_cyc && bus.o_ram_we &&
            bus.o_ram_adr >= LL && bus.o_ram_adr <= UL) begin
            if (expRx.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL rxWrUnexpected: actual write to %h, required none", bus.o_ram_adr);
            end else begin
                checkOutput("rxWrAdr", bus.o_ram_adr, expPtr);
                checkOutput("rxWrDat", bus.o_ram_dat, {24'h0, expRx.pop_front()});
                checkOutput("rxWrSel", {28'h0, bus.o_ram_sel}, 32'hF);
                expPtr = nextPtr(expPtr);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input byte unsigned b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick(1);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic cpuAccess(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input logic we, output logic [31:0] rdt, output int cntAtAck,
                             output bit sawRam);
        int  n;
        bit  done;
        bus.i_cpu_adr = adr;
        bus.i_cpu_dat = dat;
        bus.i_cpu_sel = sel;
        bus.i_cpu_we  = we;
        bus.i_cpu_cyc = 1'b1;
        rdt = '0;
        cntAtAck = -1;
        sawRam = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            if (bus.o_ram_cyc) sawRam = 1'b1;
            if (bus.o_cpu_ack) begin
                rdt      = bus.o_cpu_rdt;
                cntAtAck = int'(bus.o_fifo_count);
                done     = 1'b1;
            end
            n++;
        end
        if (!done) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL cpuAckTimeout: actual no ack at %h, required ack", adr);
        end
        tick(1);
        bus.i_cpu_cyc = 1'b0;
        bus.i_cpu_we  = 1'b0;
    endtask

    task automatic applyStimulus(input vecT v, output logic [31:0] rdt);
        int cnt;
        bit saw;
        cpuAccess(v.adr, v.dat, v.sel, v.we, rdt, cnt, saw);
    endtask

    task automatic waitIdle();
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            if (bus.o_fifo_count == 0 && !bus.o_ram_cyc) quiet++;
            else quiet = 0;
            n++;
        end
        if (quiet < 3) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL idleTimeout: actual count %0d, required 0", bus.o_fifo_count);
        end
        tick(1);
    endtask

    task automatic waitRamCyc();
        int n = 0;
        while (!bus.o_ram_cyc && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ram_cyc) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL ramCycTimeout: actual cyc 0, required 1");
        end
        tick(1);
    endtask

    task automatic doReset();
        rstN = 1'b0;
        expRx.delete();
        expPtr = LL;
        tick(2);
        rstN = 1'b1;
        tick(1);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: actual time limit hit, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecT          vecs [8];
        logic [31:0]  rdt;
        int           cnt;
        bit           saw;
        byte unsigned t1Bytes [3];
        bit [31:0]    refMem [int];

        vecs[0] = '{32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
        vecs[1] = '{32'h104, 32'h1234_5678, 4'hF, 1'b1, 32'h0};
        vecs[2] = '{32'h100, 32'h0000_00AA, 4'h1, 1'b1, 32'h0};
        vecs[3] = '{32'h100, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEAA};
        vecs[4] = '{32'h104, 32'h9900_0000, 4'h8, 1'b1, 32'h0};
        vecs[5] = '{32'h104, 32'h0,         4'hF, 1'b0, 32'h9934_5678};
        vecs[6] = '{32'h7FC, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0};
        vecs[7] = '{32'h7FC, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D};
        t1Bytes[0] = 8'h41;
        t1Bytes[1] = 8'h42;
        t1Bytes[2] = 8'h43;

        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        bus.i_cpu_adr  = '0;
        bus.i_cpu_dat  = '0;
        bus.i_cpu_sel  = '0;
        bus.i_cpu_we   = 1'b0;
        bus.i_cpu_cyc  = 1'b0;
        bus.i_ram_rdt  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRamCyc", {31'h0, bus.o_ram_cyc}, 32'h0);
        checkOutput("rstRamWe", {31'h0, bus.o_ram_we}, 32'h0);
        checkOutput("rstRamAdr", bus.o_ram_adr, 32'h0);
        checkOutput("rstRamDat", bus.o_ram_dat, 32'h0);
        checkOutput("rstRamSel", {28'h0, bus.o_ram_sel}, 32'h0);
        checkOutput("rstCpuAck", {31'h0, bus.o_cpu_ack}, 32'h0);
        checkOutput("rstWrPtr", bus.o_wr_ptr, LL);
        checkOutput("rstCount", 32'(bus.o_fifo_count), 32'h0);
        checkOutput("rstOverflow", {31'h0, bus.o_overflow}, 32'h0);
        tick(1);
        rstN = 1'b1;
        tick(2);

        $display("[TB] three rx bytes on idle bus");
        for (int i = 0; i < 3; i++) begin
            bus.i_rx_data  = t1Bytes[i];
            bus.i_rx_valid = 1'b1;
            expRx.push_back(t1Bytes[i]);
            @(negedge clk);
            if (i == 1) checkOutput("latencyN1", {31'h0, bus.o_ram_cyc}, 32'h0);
            if (i == 2) begin
                checkOutput("latencyN2", {31'h0, bus.o_ram_cyc}, 32'h1);
                checkOutput("firstAdr", bus.o_ram_adr, 32'h800);
            end
            tick(1);
        end
        bus.i_rx_valid = 1'b0;
        waitIdle();
        checkOutput("t1WrPtr", bus.o_wr_ptr, 32'h80C);
        checkOutput("t1Count", 32'(bus.o_fifo_count), 32'h0);
        checkOutput("t1Pending", 32'(expRx.size()), 32'h0);

        $display("[TB] CPU vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], rdt);
            if (!vecs[i].we) checkOutput($sformatf("cpuVec%0d", i), rdt, vecs[i].expRdt);
        end

        $display("[TB] ring wrap");
        doReset();
        for (int i = 0; i < 32'h5FF; i++) begin
            sendByte(8'(i));
            expRx.push_back(8'(i));
            tick(4);
        end
        waitIdle();
        checkOutput("presetPtr", bus.o_wr_ptr, UL);
        sendByte(8'hA5);
        expRx.push_back(8'hA5);
        waitIdle();
        checkOutput("wrapPtr", bus.o_wr_ptr, LL);
        checkOutput("wrapPending", 32'(expRx.size()), 32'h0);

        $display("[TB] round-robin arbitration");
        ackDelay = 5;
        sendByte(8'h51);
        expRx.push_back(8'h51);
        waitRamCyc();
        fork
            cpuAccess(32'h104, 32'h0, 4'hF, 1'b0, rdt, cnt, saw);
            begin
                sendByte(8'h52);
                expRx.push_back(8'h52);
            end
        join
        checkOutput("rrCpuFirstCnt", 32'(cnt), 32'h1);
        checkOutput("rrCpuFirstRdt", rdt, 32'h9934_5678);
        waitIdle();
        checkOutput("rrCpuFirstPending", 32'(expRx.size()), 32'h0);
        fork
            begin
                cpuAccess(32'h100, 32'h0, 4'hF, 1'b0, rdt, cnt, saw);
                checkOutput("rrHoldRdt", rdt, 32'hDEAD_BEAA);
                checkOutput("rrHoldCnt", 32'(cnt), 32'h1);
                cpuAccess(32'h7FC, 32'h0, 4'hF, 1'b0, rdt, cnt, saw);
            end
            begin
                tick(2);
                sendByte(8'h53);
                expRx.push_back(8'h53);
            end
        join
        checkOutput("rrRxFirstCnt", 32'(cnt), 32'h0);
        checkOutput("rrRxFirstPending", 32'(expRx.size()), 32'h0);
        checkOutput("rrRxFirstRdt", rdt, 32'hCAFE_F00D);
        ackDelay = 0;
        waitIdle();

        $display("[TB] overflow under long CPU cycle");
        ackDelay = 20;
        fork
            cpuAccess(32'h200, 32'h0BAD_F00D, 4'hF, 1'b1, rdt, cnt, saw);
            begin
                tick(2);
                for (int i = 0; i < 6; i++) begin
                    sendByte(8'(8'h61 + i));
                    if (i < FIFO_DEPTH) expRx.push_back(8'(8'h61 + i));
                end
                @(negedge clk);
                checkOutput("ovfCount", 32'(bus.o_fifo_count), 32'h4);
                checkOutput("ovfFlag", {31'h0, bus.o_overflow}, 32'h1);
                tick(1);
            end
        join
        ackDelay = 0;
        waitIdle();
        checkOutput("ovfSticky", {31'h0, bus.o_overflow}, 32'h1);
        checkOutput("ovfPending", 32'(expRx.size()), 32'h0);

`ifdef BLE_ARB_STATUS_EN
        $display("[TB] status register");
        cpuAccess(STATUS, 32'h0, 4'hF, 1'b0, rdt, cnt, saw);
        checkOutput("statRdt", rdt, {1'b1, 7'b0, 8'h00, expPtr[15:0]});
        checkOutput("statNoRam", {31'h0, saw}, 32'h0);
        cpuAccess(STATUS, 32'h8000_0000, 4'hF, 1'b1, rdt, cnt, saw);
        checkOutput("statClrNoRam", {31'h0, saw}, 32'h0);
        cpuAccess(STATUS, 32'h0, 4'hF, 1'b0, rdt, cnt, saw);
        checkOutput("statRdtCleared", rdt, {1'b0, 7'b0, 8'h00, expPtr[15:0]});
        checkOutput("statOvfCleared", {31'h0, bus.o_overflow}, 32'h0);
`else
        $display("[TB] status address forwarded to RAM");
        cpuAccess(STATUS, 32'h0, 4'hF, 1'b0, rdt, cnt, saw);
        checkOutput("statusAdrRamCyc", {31'h0, saw}, 32'h1);
        checkOutput("statusAdrRdt", rdt, 32'h0);
        checkOutput("statusOvfKept", {31'h0, bus.o_overflow}, 32'h1);
`endif

        $display("[TB] randomized mixed traffic");
        doReset();
        fork
            begin
                byte unsigned b;
                repeat (30) begin
                    tick($urandom_range(16, 24));
                    b = 8'($urandom);
                    sendByte(b);
                    expRx.push_back(b);
                end
            end
            begin
                logic [31:0] a;
                logic [31:0] d;
                logic [3:0]  s;
                logic        w;
                logic [31:0] r;
                int          c;
                bit          sw;
                repeat (40) begin
                    tick($urandom_range(0, 6));
                    ackDelay = $urandom_range(0, 3);
                    a = 32'h300 + 32'(4 * $urandom_range(0, 15));
                    d = $urandom;
                    s = 4'($urandom_range(1, 15));
                    w = 1'($urandom_range(0, 1));
                    cpuAccess(a, d, s, w, r, c, sw);
                    if (w) begin
                        refMem[int'(a)] = mergeWord(refMem.exists(int'(a)) ? refMem[int'(a)] : 32'h0, d, s);
                    end else begin
                        checkOutput("rndRead", r, refMem.exists(int'(a)) ? refMem[int'(a)] : 32'h0);
                    end
                end
            end
        join
        ackDelay = 0;
        waitIdle();
        checkOutput("rndPending", 32'(expRx.size()), 32'h0);
        checkOutput("rndOverflow", {31'h0, bus.o_overflow}, 32'h0);
        checkOutput("rndCount", 32'(bus.o_fifo_count), 32'h0);

        $display("[TB] reset during rx grant");
        ackDelay = 10;
        sendByte(8'h77);
        expRx.push_back(8'h77);
        waitRamCyc();
        tick(2);
        rstN = 1'b0;
        #1;
        checkOutput("midRstCyc", {31'h0, bus.o_ram_cyc}, 32'h0);
        checkOutput("midRstWe", {31'h0, bus.o_ram_we}, 32'h0);
        checkOutput("midRstCount", 32'(bus.o_fifo_count), 32'h0);
        checkOutput("midRstPtr", bus.o_wr_ptr, LL);
        expRx.delete();
        expPtr = LL;
        ackDelay = 0;
        tick(2);
        rstN = 1'b1;
        tick(1);
        sendByte(8'h78);
        expRx.push_back(8'h78);
        waitIdle();
        checkOutput("postRstPtr", bus.o_wr_ptr, 32'h804);
        checkOutput("postRstPending", 32'(expRx.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
